// File: rtl/sd_spi_card_responder.sv
// SD card SPI-mode responder: answers CMD0/8/55/41/58 with R1/R3/R7 frames.
// Optional CRC7 command check enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_spi_card_responder #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned RESP_DELAY_BYTES  = 1,
  parameter int unsigned ACMD41_BUSY_COUNT = 2,
  parameter logic [31:0] OCR_VALUE         = 32'h00FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_cclk,
  input  logic        sd_cs,
  input  logic        sd_cmd,
  output logic        sd_data0,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DECODE = 3'd2,
    ST_NCR    = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [6:0] NCR_BITS = 7'(RESP_DELAY_BYTES * 8);
  localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY_COUNT);

  logic [SYNC_STAGES-1:0] cclk_sync_q, cclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;
  logic        cclk_prev_q, cclk_prev_d;
  state_t      state_q, state_d;
  logic [46:0] shreg_q, shreg_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [39:0] resp_q, resp_d;
  logic [5:0]  resp_len_q, resp_len_d;
  logic [5:0]  rcnt_q, rcnt_d;
  logic [6:0]  dly_q, dly_d;
  logic        sd_data0_q, sd_data0_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        card_ready_q, card_ready_d;
  logic        in_idle_q, in_idle_d;
  logic        acmd_q, acmd_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;

  logic        cclk_s, cs_s, cmd_s, rise_s, fall_s, crc_ok_s;
  logic [5:0]  idx_s;
  logic [31:0] arg_s;

  assign cclk_s = cclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign cmd_s  = cmd_sync_q[SYNC_STAGES-1];
  assign rise_s = cclk_s & ~cclk_prev_q;
  assign fall_s = ~cclk_s & cclk_prev_q;
  // The start bit (frame[47]) is always 0, so only frame[46:0] is stored.
  assign idx_s  = shreg_q[45:40];
  assign arg_s  = shreg_q[39:8];

`ifdef SD_RESP_CRC_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      if (c[6] ^ bits[i]) c = {c[5:0], 1'b0} ^ 7'h09;
      else                c = {c[5:0], 1'b0};
    end
    return c;
  endfunction
  assign crc_ok_s = (crc7({1'b0, shreg_q[46:8]}) == shreg_q[7:1]);
`else
  assign crc_ok_s = 1'b1;
`endif

  // Input synchronizer shift chains
  always_comb begin
    cclk_sync_d = {cclk_sync_q[SYNC_STAGES-2:0], sd_cclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], sd_cs};
    cmd_sync_d  = {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd};
    cclk_prev_d = cclk_s;
  end

  // Frame receive / response transmit FSM and card state update
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    resp_d       = resp_q;
    resp_len_d   = resp_len_q;
    rcnt_d       = rcnt_q;
    dly_d        = dly_q;
    sd_data0_d   = sd_data0_q;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    card_ready_d = card_ready_q;
    in_idle_d    = in_idle_q;
    acmd_d       = acmd_q;
    busy_cnt_d   = busy_cnt_q;

    if (cs_s) begin
      state_d    = ST_HUNT;
      sd_data0_d = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (rise_s && !cmd_s) begin
            shreg_d  = 47'd0;
            bitcnt_d = 6'd1;
            state_d  = ST_CMD;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_CMD: begin
          if (rise_s) begin
            if (bitcnt_q == 6'd1 && !cmd_s) begin
              state_d = ST_HUNT;
            end else begin
              shreg_d  = {shreg_q[45:0], cmd_s};
              bitcnt_d = bitcnt_q + 6'd1;
              if (bitcnt_q == 6'd47) state_d = ST_DECODE;
              else                   state_d = ST_CMD;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_DECODE: begin
          cmd_valid_d = 1'b1;
          cmd_index_d = idx_s;
          cmd_arg_d   = arg_s;
          dly_d       = NCR_BITS;
          rcnt_d      = 6'd0;
          resp_len_d  = 6'd8;
          state_d     = ST_NCR;
          if (!crc_ok_s) begin
            resp_d = {4'b0000, 1'b1, 2'b00, in_idle_q, 32'd0};
          end else begin
            acmd_d = 1'b0;
            case (idx_s)
              6'd0: begin
                in_idle_d    = 1'b1;
                card_ready_d = 1'b0;
                busy_cnt_d   = 8'd0;
                resp_d       = {8'h01, 32'd0};
              end
              6'd8: begin
                resp_d     = {7'd0, in_idle_q, 8'h00, 8'h00, 4'h0,
                              (arg_s[11:8] == 4'h1) ? 4'h1 : 4'h0, arg_s[7:0]};
                resp_len_d = 6'd40;
              end
              6'd55: begin
                acmd_d = 1'b1;
                resp_d = {7'd0, in_idle_q, 32'd0};
              end
              6'd41: begin
                if (busy_cnt_q < BUSY_MAX) begin
                  busy_cnt_d = busy_cnt_q + 8'd1;
                  resp_d     = {7'd0, in_idle_q, 32'd0};
                end else begin
                  in_idle_d    = 1'b0;
                  card_ready_d = 1'b1;
                  resp_d       = 40'd0;
                end
              end
              6'd58: begin
                resp_d     = {7'd0, in_idle_q, card_ready_q, card_ready_q, OCR_VALUE[29:0]};
                resp_len_d = 6'd40;
              end
              default: begin
                resp_d = {5'd0, 1'b1, 1'b0, in_idle_q, 32'd0};
              end
            endcase
          end
        end
        ST_NCR: begin
          if (fall_s) begin
            sd_data0_d = 1'b1;
            dly_d      = dly_q - 7'd1;
            if (dly_q == 7'd1) state_d = ST_RESP;
            else               state_d = ST_NCR;
          end else begin
            state_d = ST_NCR;
          end
        end
        ST_RESP: begin
          if (fall_s) begin
            // One extra falling edge releases the line after the last bit was sampled.
            if (rcnt_q == resp_len_q) begin
              sd_data0_d = 1'b1;
              state_d    = ST_HUNT;
            end else begin
              sd_data0_d = resp_q[39];
              resp_d     = {resp_q[38:0], 1'b0};
              rcnt_d     = rcnt_q + 6'd1;
            end
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d    = ST_HUNT;
          sd_data0_d = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      cmd_sync_q   <= '1;
      cclk_prev_q  <= 1'b0;
      state_q      <= ST_HUNT;
      shreg_q      <= 47'd0;
      bitcnt_q     <= 6'd0;
      resp_q       <= 40'd0;
      resp_len_q   <= 6'd8;
      rcnt_q       <= 6'd0;
      dly_q        <= 7'd0;
      sd_data0_q   <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= 6'd0;
      cmd_arg_q    <= 32'd0;
      card_ready_q <= 1'b0;
      in_idle_q    <= 1'b1;
      acmd_q       <= 1'b0;
      busy_cnt_q   <= 8'd0;
    end else begin
      cclk_sync_q  <= cclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      cmd_sync_q   <= cmd_sync_d;
      cclk_prev_q  <= cclk_prev_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      resp_q       <= resp_d;
      resp_len_q   <= resp_len_d;
      rcnt_q       <= rcnt_d;
      dly_q        <= dly_d;
      sd_data0_q   <= sd_data0_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      card_ready_q <= card_ready_d;
      in_idle_q    <= in_idle_d;
      acmd_q       <= acmd_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign sd_data0   = sd_data0_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign card_ready = card_ready_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench for sd_spi_card_responder: SPI host model plus a card-state reference model.
module tb_sd_spi_card_responder;

  localparam int          SYNC_STAGES = 2;
  localparam int          RESP_DELAY  = 1;
  localparam int          BUSY_COUNT  = 2;
  localparam logic [31:0] OCR         = 32'h00FF8000;
  localparam int          H           = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_cclk, sd_cs, sd_cmd;
  logic        sd_data0, cmd_valid, card_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int n_cmp = 0;
  int n_fail = 0;
  int vcnt = 0;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;

  // reference card state
  bit m_idle, m_ready;
  int m_busy;
  logic [7:0] exp_q[$];

  sd_spi_card_responder #(
    .SYNC_STAGES(SYNC_STAGES), .RESP_DELAY_BYTES(RESP_DELAY),
    .ACMD41_BUSY_COUNT(BUSY_COUNT), .OCR_VALUE(OCR)
  ) dut (
    .clk(clk), .rst(rst), .sd_cclk(sd_cclk), .sd_cs(sd_cs), .sd_cmd(sd_cmd),
    .sd_data0(sd_data0), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .card_ready(card_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      vcnt     <= vcnt + 1;
      last_idx <= cmd_index;
      last_arg <= cmd_arg;
    end
  end

  // CRC7 as polynomial division of the 40-bit message by x^7+x^3+1
  function automatic logic [7:0] crc_byte_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] v;
    v = {2'b01, idx, arg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return {v[6:0], 1'b1};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_ready = 1'b0; m_busy = 0;
  endtask

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_good);
    logic [7:0] r1;
    exp_q.delete();
`ifdef SD_RESP_CRC_CHECK_EN
    if (!crc_good) begin
      exp_q.push_back(8'h08 | {7'd0, m_idle});
      return;
    end
`endif
    case (idx)
      6'd0: begin
        m_idle = 1'b1; m_ready = 1'b0; m_busy = 0;
        exp_q.push_back(8'h01);
      end
      6'd8: begin
        exp_q.push_back({7'd0, m_idle});
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back((arg[11:8] == 4'd1) ? 8'h01 : 8'h00);
        exp_q.push_back(arg[7:0]);
      end
      6'd55: exp_q.push_back({7'd0, m_idle});
      6'd41: begin
        if (m_busy < BUSY_COUNT) begin
          m_busy++;
          exp_q.push_back({7'd0, m_idle});
        end else begin
          m_idle = 1'b0; m_ready = 1'b1;
          exp_q.push_back(8'h00);
        end
      end
      6'd58: begin
        exp_q.push_back({7'd0, m_idle});
        r1 = OCR[31:24];
        r1[7] = m_ready; r1[6] = m_ready;
        exp_q.push_back(r1);
        exp_q.push_back(OCR[23:16]);
        exp_q.push_back(OCR[15:8]);
        exp_q.push_back(OCR[7:0]);
      end
      default: exp_q.push_back(m_idle ? 8'h05 : 8'h04);
    endcase
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sd_cmd = b;
    #(H);
    sd_cclk = 1'b1;
    r = sd_data0;
    #(H);
    sd_cclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] frame [6];
    logic [7:0] rx;
    int v0;
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24]; frame[2] = arg[23:16];
    frame[3] = arg[15:8];  frame[4] = arg[7:0];
    frame[5] = crc;
    model_cmd(idx, arg, crc == crc_byte_of(idx, arg));
    v0 = vcnt;
    for (int i = 0; i < 6; i++) xfer(frame[i], rx);
    for (int i = 0; i < RESP_DELAY; i++) begin
      xfer(8'hFF, rx);
      n_cmp++;
      if (rx !== 8'hFF) begin
        n_fail++;
        $display("FAIL ncr cmd%0d: got %h expected ff", idx, rx);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      xfer(8'hFF, rx);
      n_cmp++;
      if (rx !== exp_q[i]) begin
        n_fail++;
        $display("FAIL resp cmd%0d byte%0d: got %h expected %h", idx, i, rx, exp_q[i]);
      end
    end
    n_cmp++;
    if (vcnt !== v0 + 1) begin
      n_fail++;
      $display("FAIL cmd_valid_count cmd%0d: got %0d expected %0d", idx, vcnt - v0, 1);
    end
    n_cmp++;
    if (last_idx !== idx || last_arg !== arg) begin
      n_fail++;
      $display("FAIL decode cmd%0d: got %0d/%h expected %0d/%h", idx, last_idx, last_arg, idx, arg);
    end
    n_cmp++;
    if (card_ready !== m_ready) begin
      n_fail++;
      $display("FAIL card_ready cmd%0d: got %b expected %b", idx, card_ready, m_ready);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (sd_data0 !== 1'b1 || cmd_valid !== 1'b0 || card_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b expected 100", sd_data0, cmd_valid, card_ready);
    end
    n_cmp++;
    if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cmd: got %0d/%h expected 0/00000000", cmd_index, cmd_arg);
    end
  endtask

  task automatic test_init_sequence();
    do_cmd(6'd0, 32'h0, 8'h95);
    do_cmd(6'd8, 32'h000001AA, 8'h87);
    for (int i = 0; i < 3; i++) do_cmd(6'd41, 32'h40000000, 8'h77);
    do_cmd(6'd58, 32'h0, 8'hFD);
    do_cmd(6'd0, 32'h0, 8'h95);
    do_cmd(6'd58, 32'h0, 8'hFD);
  endtask

  task automatic test_cs_abort();
    logic [47:0] f;
    logic r;
    int v0;
    f = {8'h48, 32'h000001AA, 8'h87};
    v0 = vcnt;
    for (int i = 47; i >= 28; i--) spi_bit(f[i], r);
    sd_cs = 1'b1;
    #(300);
    sd_cs = 1'b0;
    #(200);
    // cs rising in the same clk as the last rising cclk edge
    for (int i = 47; i >= 1; i--) spi_bit(f[i], r);
    sd_cmd = f[0];
    #(H);
    sd_cclk = 1'b1;
    sd_cs = 1'b1;
    #(H);
    sd_cclk = 1'b0;
    #(300);
    n_cmp++;
    if (vcnt !== v0) begin
      n_fail++;
      $display("FAIL cs_drop_valid: got %0d expected 0", vcnt - v0);
    end
    sd_cs = 1'b0;
    #(200);
    do_cmd(6'd0, 32'h0, 8'h95);
    do_cmd(6'd5, 32'h0, crc_byte_of(6'd5, 32'h0));
  endtask

  task automatic test_bad_crc();
    do_cmd(6'd0, 32'h0, 8'h00);
  endtask

  task automatic test_random();
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  rx;
    int sel, gaps;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 6);
      arg = $urandom;
      case (sel)
        0: idx = 6'd0;
        1: idx = 6'd8;
        2: idx = 6'd55;
        3, 4: idx = 6'd41;
        5: idx = 6'd58;
        default: begin
          idx = 6'($urandom_range(0, 63));
          while (idx == 6'd0 || idx == 6'd8 || idx == 6'd55 || idx == 6'd41 || idx == 6'd58)
            idx = 6'($urandom_range(0, 63));
        end
      endcase
      if (idx == 6'd8 && $urandom_range(0, 1) == 1) arg[11:8] = 4'h1;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        xfer(8'hFF, rx);
        n_cmp++;
        if (rx !== 8'hFF) begin
          n_fail++;
          $display("FAIL idle_line: got %h expected ff", rx);
        end
      end
      do_cmd(idx, arg, crc_byte_of(idx, arg));
    end
  endtask

  task automatic test_rst_during_resp();
    logic [7:0] rx;
    logic r;
    do_cmd(6'd41, 32'h40000000, 8'h77);
    xfer(8'h40, rx); xfer(8'h00, rx); xfer(8'h00, rx);
    xfer(8'h00, rx); xfer(8'h00, rx); xfer(8'h95, rx);
    for (int i = 0; i < RESP_DELAY; i++) xfer(8'hFF, rx);
    spi_bit(1'b1, r);
    spi_bit(1'b1, r);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sd_data0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_bit_before_rst: got %b expected 0", sd_data0);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (sd_data0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_data0_async: got %b expected 1", sd_data0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    test_reset();
    #(200);
    do_cmd(6'd58, 32'h0, 8'hFD);
    do_cmd(6'd0, 32'h0, 8'h95);
  endtask

  initial begin
    rst = 1'b1; sd_cs = 1'b1; sd_cclk = 1'b0; sd_cmd = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    sd_cs = 1'b0;
    #(200);
    test_init_sequence();
    test_cs_abort();
    test_bad_crc();
    test_random();
    test_rst_during_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
